// File: rtl/sb_pkg.sv
// Shared types and helpers for the stream buffer: cell state encoding and AXI ID mapping.
package sb_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      CELL_INVALID = 2'd0,
      CELL_FILLING = 2'd1,
      CELL_VALID   = 2'd2,
      CELL_STALE   = 2'd3
   } cell_state_t;

   // AXI ID owned by stream buffer cell idx.
   function automatic logic [3:0] sb_id(input int idx, input int mem_id = 0);
      return 4'(mem_id + idx);
   endfunction

endpackage

// File: rtl/sb_ctrl_rr_arbiter.sv
// Round-robin arbiter; the grant is frozen while the downstream handshake is stalled.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               lock,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx,
   output logic               grant_valid
);

   logic [IW-1:0] r_ptr;
   logic          r_hold;
   logic [IW-1:0] r_hold_idx;
   logic          w_found;
   logic [IW-1:0] w_idx;
   logic [IW-1:0] w_cand;

   // r_ptr is the first index searched: one past the last completed grant.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = IW'((int'(r_ptr) + k) % NUM_REQ);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
      grant_idx   = r_hold ? r_hold_idx : w_idx;
      grant_valid = r_hold ? req[r_hold_idx] : w_found;
      grant       = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_hold     <= 1'b0;
         r_hold_idx <= '0;
      end else if (grant_valid) begin
         if (lock) begin
            r_hold     <= 1'b1;
            r_hold_idx <= grant_idx;
         end else begin
            r_hold <= 1'b0;
            r_ptr  <= IW'((int'(grant_idx) + 1) % NUM_REQ);
         end
      end else begin
         r_hold <= 1'b0;
      end
   end

endmodule

// File: rtl/sb_ctrl.sv
// Stream buffer controller: line lookup, next-line allocation, flush, and a shared AXI read port.
module sb_ctrl
   import sb_pkg::*;
#(
   parameter  int NUM_CELLS          = 4,
   parameter  int LINE_SIZE          = 4,
   parameter  int BLOCK_OFFSET_WIDTH = 2,
   parameter  int MEM_ID             = 0,
   localparam int LW                 = ADDR_WIDTH - BLOCK_OFFSET_WIDTH - 2,
   localparam int CW                 = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             req_valid,
   input  logic [LW-1:0]                    req_addr,
   input  logic                             flush,
   output logic                             resp_valid,
   output logic                             resp_hit,
   output logic                             resp_pending,
   output logic [CW-1:0]                    resp_cell,
   output logic [NUM_CELLS-1:0]             cell_enable,
   output logic [NUM_CELLS-1:0]             cell_stale,
   output logic [ADDR_WIDTH-3:0]            cell_addr,
   input  logic [NUM_CELLS-1:0]             cell_available,
   input  logic [NUM_CELLS-1:0]             cell_ar_valid,
   input  logic [ADDR_WIDTH*NUM_CELLS-1:0]  cell_araddr,
   output logic [NUM_CELLS-1:0]             cell_ar_ready,
   output logic                             m_arvalid,
   input  logic                             m_arready,
   output logic [ADDR_WIDTH-1:0]            m_araddr,
   output logic [3:0]                       m_arid,
   output logic [7:0]                       m_arlen,
   input  logic                             m_rvalid,
   input  logic                             m_rlast,
   input  logic [3:0]                       m_rid,
   input  logic [DATA_WIDTH-1:0]            m_rdata,
   output logic                             m_rready,
   output logic [NUM_CELLS-1:0]             cell_rvalid,
   output logic [NUM_CELLS-1:0]             cell_rlast,
   output logic [DATA_WIDTH-1:0]            cell_rdata,
   output logic [2*NUM_CELLS-1:0]           dbg_cell_state
);

   cell_state_t          r_state [NUM_CELLS];
   cell_state_t          w_state_nxt [NUM_CELLS];
   logic [LW-1:0]        r_tag [NUM_CELLS];
   logic [CW-1:0]        r_vp;
   logic                 r_resp_valid, r_resp_hit, r_resp_pending;
   logic [CW-1:0]        r_resp_cell;
   logic [NUM_CELLS-1:0] r_cell_enable;
   logic [ADDR_WIDTH-3:0] r_cell_addr;

   logic                 w_lookup, w_hit, w_pend, w_inv_found, w_vic_found;
   logic [CW-1:0]        w_hit_idx, w_pend_idx, w_inv_idx, w_vic_idx, w_vcand;
   logic                 w_alloc, w_evict;
   logic [CW-1:0]        w_alloc_idx;
   logic [LW-1:0]        w_next_tag;
   logic [NUM_CELLS-1:0] w_rvalid, w_ar_req, w_gnt;
   logic [CW-1:0]        w_gnt_idx;
   logic                 w_gnt_valid;

   always_comb begin
      w_hit       = 1'b0;
      w_hit_idx   = '0;
      w_pend      = 1'b0;
      w_pend_idx  = '0;
      w_inv_found = 1'b0;
      w_inv_idx   = '0;
      w_vic_found = 1'b0;
      w_vic_idx   = '0;
      w_vcand     = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (!w_hit && r_state[i] == CELL_VALID && r_tag[i] == req_addr) begin
            w_hit     = 1'b1;
            w_hit_idx = CW'(i);
         end
         if (!w_pend && r_state[i] == CELL_FILLING && r_tag[i] == req_addr) begin
            w_pend     = 1'b1;
            w_pend_idx = CW'(i);
         end
         if (!w_inv_found && r_state[i] == CELL_INVALID) begin
            w_inv_found = 1'b1;
            w_inv_idx   = CW'(i);
         end
      end
      // Victim search starts at vp and takes the first VALID cell from there.
      for (int k = 0; k < NUM_CELLS; k++) begin
         w_vcand = CW'((int'(r_vp) + k) % NUM_CELLS);
         if (!w_vic_found && r_state[w_vcand] == CELL_VALID) begin
            w_vic_found = 1'b1;
            w_vic_idx   = w_vcand;
         end
      end
      w_lookup    = req_valid && !flush;
      w_alloc     = w_lookup && !w_hit && !w_pend && (w_inv_found || w_vic_found);
      w_evict     = w_alloc && !w_inv_found;
      w_alloc_idx = w_inv_found ? w_inv_idx : w_vic_idx;
      w_next_tag  = req_addr + LW'(1);
   end

   always_comb begin
      for (int i = 0; i < NUM_CELLS; i++) begin
         w_state_nxt[i] = r_state[i];
         case (r_state[i])
            CELL_FILLING: begin
               if (flush)
                  w_state_nxt[i] = cell_available[i] ? CELL_INVALID : CELL_STALE;
               else if (cell_available[i])
                  w_state_nxt[i] = CELL_VALID;
            end
            CELL_VALID:   if (flush) w_state_nxt[i] = CELL_INVALID;
            CELL_STALE:   if (w_rvalid[i] && m_rlast) w_state_nxt[i] = CELL_INVALID;
            default:      ;
         endcase
         if (w_alloc && w_alloc_idx == CW'(i))
            w_state_nxt[i] = CELL_FILLING;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            r_state[i] <= CELL_INVALID;
            r_tag[i]   <= '0;
         end
         r_vp           <= '0;
         r_resp_valid   <= 1'b0;
         r_resp_hit     <= 1'b0;
         r_resp_pending <= 1'b0;
         r_resp_cell    <= '0;
         r_cell_enable  <= '0;
         r_cell_addr    <= '0;
      end else begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            r_state[i] <= w_state_nxt[i];
            if (w_alloc && w_alloc_idx == CW'(i))
               r_tag[i] <= w_next_tag;
         end
         if (w_evict)
            r_vp <= CW'((int'(w_alloc_idx) + 1) % NUM_CELLS);
         if (w_alloc)
            r_cell_addr <= (ADDR_WIDTH-2)'(w_next_tag);
         r_resp_valid   <= req_valid;
         r_resp_hit     <= w_lookup && w_hit;
         r_resp_pending <= w_lookup && !w_hit && w_pend;
         r_resp_cell    <= !w_lookup ? '0 : w_hit ? w_hit_idx : w_pend ? w_pend_idx :
                           w_alloc ? w_alloc_idx : '0;
         r_cell_enable  <= w_alloc ? (NUM_CELLS'(1) << w_alloc_idx) : '0;
      end
   end

   assign w_ar_req = rst_n ? cell_ar_valid : '0;

   rr_arbiter #(.NUM_REQ(NUM_CELLS)) u_ar_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (w_ar_req),
      .lock        (m_arvalid && !m_arready),
      .grant       (w_gnt),
      .grant_idx   (w_gnt_idx),
      .grant_valid (w_gnt_valid)
   );

   always_comb begin
      for (int i = 0; i < NUM_CELLS; i++) begin
         w_rvalid[i]                  = m_rvalid && (m_rid == sb_id(i, MEM_ID));
         dbg_cell_state[2*i +: 2]     = r_state[i];
         cell_stale[i]                = (r_state[i] == CELL_STALE);
      end
      m_araddr = cell_araddr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   end

   assign m_arvalid     = w_gnt_valid;
   assign m_arid        = sb_id(int'(w_gnt_idx), MEM_ID);
   assign m_arlen       = 8'(LINE_SIZE);
   assign cell_ar_ready = m_arready ? w_gnt : '0;
   assign m_rready      = 1'b1;
   assign cell_rvalid   = w_rvalid;
   assign cell_rlast    = m_rlast ? w_rvalid : '0;
   assign cell_rdata    = m_rdata;

   assign resp_valid   = r_resp_valid;
   assign resp_hit     = r_resp_hit;
   assign resp_pending = r_resp_pending;
   assign resp_cell    = r_resp_cell;
   assign cell_enable  = r_cell_enable;
   assign cell_addr    = r_cell_addr;

endmodule

// File: tb/tb_sb_ctrl.sv
// Bench for sb_ctrl: directed scenarios plus random traffic against a cell-level reference model.
module tb_sb_ctrl;

  localparam int NC = 4;
  localparam int S_INV = 0, S_FILL = 1, S_VALID = 2, S_STALE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [27:0] req_addr;
  logic        flush;
  logic        resp_valid, resp_hit, resp_pending;
  logic [1:0]  resp_cell;
  logic [3:0]  cell_enable, cell_stale;
  logic [29:0] cell_addr;
  logic [3:0]  cell_available, cell_ar_valid, cell_ar_ready;
  logic [127:0] cell_araddr;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic        m_rvalid, m_rlast, m_rready;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic [3:0]  cell_rvalid, cell_rlast;
  logic [31:0] cell_rdata;
  logic [7:0]  dbg_cell_state;

  sb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_pending(resp_pending),
    .resp_cell(resp_cell), .cell_enable(cell_enable), .cell_stale(cell_stale),
    .cell_addr(cell_addr), .cell_available(cell_available), .cell_ar_valid(cell_ar_valid),
    .cell_araddr(cell_araddr), .cell_ar_ready(cell_ar_ready), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rready(m_rready), .cell_rvalid(cell_rvalid), .cell_rlast(cell_rlast),
    .cell_rdata(cell_rdata), .dbg_cell_state(dbg_cell_state)
  );

  always #5 clk = ~clk;

  // reference model
  int          md_st [NC];
  logic [27:0] md_tag [NC];
  int          md_vp, md_ar_next, md_ar_hidx;
  bit          md_ar_hold;
  bit          e_rv, e_hit, e_pend;
  int          e_cell;
  logic [3:0]  e_en;
  logic [29:0] e_addr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      md_st[i] = S_INV;
      md_tag[i] = '0;
    end
    md_vp = 0; md_ar_next = 0; md_ar_hold = 0; md_ar_hidx = 0;
    e_rv = 0; e_hit = 0; e_pend = 0; e_cell = 0; e_en = '0; e_addr = '0;
  endtask

  task automatic idle();
    req_valid = 0; req_addr = '0; flush = 0; cell_available = '0; cell_ar_valid = '0;
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rid = '0; m_rdata = '0;
  endtask

  // Inputs are set at a falling edge; checks combinational outputs, advances one clock, checks registers.
  task automatic cycle();
    int g, hi, pi, ai;
    bit gv, evict;
    logic [3:0] rv, stl;
    logic [7:0] dbg;
    logic [27:0] nt;
    #1;
    gv = 0; g = 0;
    if (rst_n) begin
      if (md_ar_hold) begin
        g = md_ar_hidx;
        gv = cell_ar_valid[g];
      end else begin
        for (int k = 0; k < NC; k++) begin
          int c;
          c = (md_ar_next + k) % NC;
          if (!gv && cell_ar_valid[c]) begin gv = 1; g = c; end
        end
      end
    end
    chk("m_arvalid", m_arvalid, gv);
    if (gv) begin
      chk("m_arid", m_arid, g);
      chk("m_araddr", m_araddr, cell_araddr[g*32 +: 32]);
      chk("m_arlen", m_arlen, 4);
      chk("cell_ar_ready", cell_ar_ready, m_arready ? (4'b1 << g) : 4'b0);
    end
    rv = '0;
    for (int i = 0; i < NC; i++) rv[i] = m_rvalid && (m_rid == 4'(i));
    chk("cell_rvalid", cell_rvalid, rv);
    chk("cell_rlast", cell_rlast, rv & {4{m_rlast}});
    chk("m_rready", m_rready, 1);

    if (!rst_n) begin
      model_reset();
    end else begin
      if (gv) begin
        if (!m_arready) begin md_ar_hold = 1; md_ar_hidx = g; end
        else begin md_ar_hold = 0; md_ar_next = (g + 1) % NC; end
      end else md_ar_hold = 0;
      hi = -1; pi = -1; ai = -1; evict = 0;
      if (req_valid && !flush) begin
        for (int i = 0; i < NC; i++) begin
          if (hi < 0 && md_st[i] == S_VALID && md_tag[i] == req_addr) hi = i;
          if (pi < 0 && md_st[i] == S_FILL && md_tag[i] == req_addr) pi = i;
        end
        if (hi < 0 && pi < 0) begin
          for (int i = 0; i < NC; i++) if (ai < 0 && md_st[i] == S_INV) ai = i;
          for (int k = 0; k < NC; k++) begin
            int c;
            c = (md_vp + k) % NC;
            if (ai < 0 && md_st[c] == S_VALID) begin ai = c; evict = 1; end
          end
        end
      end
      e_rv = req_valid;
      e_hit = (hi >= 0);
      e_pend = (hi < 0 && pi >= 0);
      e_cell = (hi >= 0) ? hi : (pi >= 0) ? pi : (ai >= 0) ? ai : 0;
      e_en = (ai >= 0) ? (4'b1 << ai) : 4'b0;
      nt = req_addr + 28'd1;
      if (ai >= 0) e_addr = {2'b00, nt};
      for (int i = 0; i < NC; i++) begin
        if (md_st[i] == S_FILL) begin
          if (flush) md_st[i] = cell_available[i] ? S_INV : S_STALE;
          else if (cell_available[i]) md_st[i] = S_VALID;
        end else if (md_st[i] == S_VALID) begin
          if (flush) md_st[i] = S_INV;
        end else if (md_st[i] == S_STALE) begin
          if (rv[i] && m_rlast) md_st[i] = S_INV;
        end
      end
      if (ai >= 0) begin md_st[ai] = S_FILL; md_tag[ai] = nt; end
      if (evict) md_vp = (ai + 1) % NC;
    end

    @(posedge clk);
    @(negedge clk);
    stl = '0; dbg = '0;
    for (int i = 0; i < NC; i++) begin
      stl[i] = (md_st[i] == S_STALE);
      dbg[2*i +: 2] = 2'(md_st[i]);
    end
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_hit", resp_hit, e_hit);
    chk("resp_pending", resp_pending, e_pend);
    chk("resp_cell", resp_cell, e_cell);
    chk("cell_enable", cell_enable, e_en);
    chk("cell_addr", cell_addr, e_addr);
    chk("cell_stale", cell_stale, stl);
    chk("cell_state", dbg_cell_state, dbg);
  endtask

  task automatic lookup(input logic [27:0] a);
    idle(); req_valid = 1; req_addr = a; cycle(); idle();
  endtask

  task automatic beat(input logic [3:0] id, input bit last, input logic [3:0] avail);
    idle(); m_rvalid = 1; m_rid = id; m_rlast = last; m_rdata = $urandom;
    cell_available = avail; cycle(); idle();
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; cycle(); cycle(); rst_n = 1;
  endtask

  initial begin
    int id_seq [5];
    logic [31:0] held_addr;
    model_reset();
    for (int i = 0; i < NC; i++) cell_araddr[i*32 +: 32] = $urandom;
    @(negedge clk);
    do_reset();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_cell_enable", cell_enable, 0);
    chk("rst_cell_addr", cell_addr, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_state", dbg_cell_state, 0);

    // cold miss and its AR request
    lookup(28'h100);
    chk("cold_hit", resp_hit, 0);
    chk("cold_enable", cell_enable, 4'b0001);
    chk("cold_addr", cell_addr, 30'h101);
    cell_ar_valid = 4'b0001; cell_araddr[31:0] = 32'h0000_0404; m_arready = 1;
    #1;
    chk("cold_arid", m_arid, 0);
    chk("cold_arlen", m_arlen, 4);
    chk("cold_araddr", m_araddr, 32'h0000_0404);
    cycle(); idle();

    // fill cell 0, pending lookup during fill, hit afterwards
    beat(4'h0, 0, 4'b0000);
    idle(); m_rvalid = 1; m_rid = 4'h0; req_valid = 1; req_addr = 28'h101; cycle(); idle();
    chk("fill_pending", resp_pending, 1);
    chk("fill_no_alloc", cell_enable, 0);
    beat(4'h0, 0, 4'b0000);
    beat(4'h0, 1, 4'b0001);
    lookup(28'h101);
    chk("hit", resp_hit, 1);
    chk("hit_cell", resp_cell, 0);

    // AR arbitration: locked grant then rotation
    do_reset();
    idle(); cell_ar_valid = 4'hF; m_arready = 0;
    held_addr = cell_araddr[31:0];
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("lock_arid", m_arid, 0);
      chk("lock_araddr", m_araddr, held_addr);
      cycle();
      cell_ar_valid = 4'hF; m_arready = 0;
    end
    id_seq = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 5; c++) begin
      cell_ar_valid = 4'hF; m_arready = 1;
      #1;
      chk("rr_arid", m_arid, id_seq[c]);
      cycle();
    end
    idle();

    // flush while cell 2 is mid-fill
    do_reset();
    lookup(28'h200); lookup(28'h300); lookup(28'h400);
    beat(4'h2, 0, 4'b0000);
    beat(4'h2, 0, 4'b0000);
    idle(); flush = 1; req_valid = 1; req_addr = 28'h401; cycle(); idle();
    chk("flush_hit", resp_hit, 0);
    chk("flush_enable", cell_enable, 0);
    chk("flush_stale2", cell_stale[2], 1);
    beat(4'h2, 0, 4'b0000);
    chk("stale_hold", cell_stale[2], 1);
    beat(4'h2, 1, 4'b0000);
    chk("stale_clear", cell_stale[2], 0);
    chk("stale_to_invalid", dbg_cell_state[5:4], 0);

    // victim rotation
    do_reset();
    lookup(28'h10); lookup(28'h20); lookup(28'h30); lookup(28'h40);
    idle(); cell_available = 4'hF; cycle(); idle();
    for (int c = 0; c < 4; c++) begin
      lookup(28'h50 + 28'(c * 16));
      chk("evict_order", cell_enable, 4'b1 << c);
    end
    lookup(28'h90);
    chk("all_filling_no_alloc", cell_enable, 0);

    // reset mid-fill and a stray RID
    beat(4'h0, 0, 4'b0000);
    idle(); rst_n = 0; m_rvalid = 1; m_rid = 4'h0; cycle(); rst_n = 1; idle();
    chk("rst_mid_state", dbg_cell_state, 0);
    chk("rst_mid_enable", cell_enable, 0);
    chk("rst_mid_resp", resp_valid, 0);
    idle(); m_rvalid = 1; m_rid = 4'hF; m_rlast = 1;
    #1;
    chk("stray_rid", cell_rvalid, 0);
    cycle(); idle();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr = 28'h500 + 28'($urandom_range(0, 7));
      flush = ($urandom_range(0, 24) == 0);
      cell_available = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      m_rvalid = 1'($urandom_range(0, 1));
      m_rid = 4'($urandom_range(0, 5));
      m_rlast = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
      m_arready = 1'($urandom_range(0, 1));
      if (!md_ar_hold) begin
        cell_ar_valid = 4'($urandom);
        for (int i = 0; i < NC; i++) cell_araddr[i*32 +: 32] = $urandom;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
